chimera_cluster_pwr_seq: RTL
============================

Name: chimera_cluster_pwr_seq

Overview:
- Schedules clock-gate enable and reset release/assert for the external Snitch clusters.
- Sits behind the top-level register region. The register file drives per-cluster enable requests; this block answers with gate, reset and wake outputs.
- Serializes transitions: only one cluster powers up or down at a time, to bound inrush and share one timing counter. Pending requests are granted round-robin.
- Issues a one-cycle wake pulse once a cluster is out of reset, so its cores fetch from the shared boot ROM.

Parameters:
- NumClusters, 5, number of sequenced clusters.
- ClkSettleCycles, 4, cycles with clock running and reset held before release; must be >= 1.
- RstHoldCycles, 8, cycles between reset release and wake pulse, and reset-asserted cycles before gating on shutdown; must be >= 1.
- CntWidth, 16, shared counter width; every cycle parameter must fit.
- TimeoutCycles, 1024, drain timeout; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cluster_en_i  in  NumClusters  requested power state per cluster (level)
- cluster_busy_i  in  NumClusters  cluster has outstanding work or transactions
- clk_en_o  out  NumClusters  clock-gate enable per cluster
- cluster_rst_no  out  NumClusters  active-low cluster reset
- wake_pulse_o  out  NumClusters  one-cycle wake interrupt to the cluster
- cluster_on_o  out  NumClusters  cluster fully up (status)
- seq_busy_o  out  1  a transition is in progress
- active_idx_o  out  $clog2(NumClusters)  cluster currently sequenced
- timeout_err_o  out  NumClusters  sticky drain-timeout flag

Behaviour:
- Reset values (asynchronous): clk_en_o=0, cluster_rst_no=0, wake_pulse_o=0, cluster_on_o=0, seq_busy_o=0, active_idx_o=0, timeout_err_o=0. FSM=IDLE, round-robin pointer=0, counter=0.
- pending[i] = cluster_en_i[i] XOR cluster_on_o[i].
- Arbitration: in IDLE, grant the first pending index at or after the pointer, wrapping. The pointer becomes grant+1 mod NumClusters. The grant is latched into active_idx_o, and the direction is latched from cluster_en_i[g].
- cluster_en_i is sampled only at grant. Changes mid-sequence are ignored until the sequence returns to IDLE; pending is then re-evaluated.
- FSM states and transitions (g = latched grant):
  - IDLE -> UP_CLK if en, DN_DRAIN if not. seq_busy_o=1 from the next cycle.
  - UP_CLK: clk_en_o[g]=1 on entry, counter=ClkSettleCycles-1, decrement each cycle. At 0: cluster_rst_no[g]=1, counter=RstHoldCycles-1, -> UP_RST.
  - UP_RST: count down. At 0: wake_pulse_o[g]=1, -> UP_WAKE.
  - UP_WAKE: one cycle. wake_pulse_o[g]=0, cluster_on_o[g]=1, timeout_err_o[g]=0, -> IDLE.
  - DN_DRAIN: wait for cluster_busy_i[g]==0. Then cluster_rst_no[g]=0, counter=RstHoldCycles-1, -> DN_RST.
  - DN_RST: count down. At 0: clk_en_o[g]=0, cluster_on_o[g]=0, -> IDLE.
- Power-up latency, with grant in IDLE at cycle t (defaults in brackets):
  - clk_en_o rises at t+1.
  - reset releases at t+1+ClkSettleCycles [t+5].
  - wake pulse at t+1+ClkSettleCycles+RstHoldCycles [t+13].
  - cluster_on_o at +1 [t+14].
  - IDLE again at t+14.
- Power-down latency with busy low: reset asserted at t+2, gate off at t+2+RstHoldCycles [t+10].
- seq_busy_o=0 in IDLE, 1 in every other state. No new grant is made in the cycle the FSM returns to IDLE; arbitration resumes the following cycle.
- Simultaneous requests from all clusters are served strictly round-robin: 0,1,2,3,4 from reset.
- A wake pulse is never asserted while cluster_rst_no[g]=0. The clock is never gated while cluster_rst_no[g]=1.
- Reset mid-sequence: all outputs return to reset values immediately, i.e. every cluster is gated and held in reset.

Optional Feature:
- Macro: CHIMERA_PWR_SEQ_TIMEOUT_EN.
- Defined: on DN_DRAIN entry the counter loads TimeoutCycles-1. If it reaches 0 with busy still high, set timeout_err_o[g]=1 and force the DN_RST path.
- timeout_err_o[g] stays set until the next successful power-up of g.
- Not defined: DN_DRAIN waits indefinitely and timeout_err_o is tied to 0.

Decomposition:
- chimera_pkg additions:
  - pwr_seq_state_e enum: IDLE, UP_CLK, UP_RST, UP_WAKE, DN_DRAIN, DN_RST.
  - Default constants for ClkSettleCycles and RstHoldCycles.
  - Typedef of a cluster mask sized by ExtClusters.
- One sub-module, chimera_rr_pick: combinational round-robin first-set picker with pointer input, returning grant index and valid.

Test Plan:
1. Reset release, then cluster_en_i=5'b00001 at cycle 0:
   - clk_en_o[0] at 1, cluster_rst_no[0] at 5, wake_pulse_o[0] high only at 13, cluster_on_o[0] at 14.
   - No other bits toggle.
2. cluster_en_i=5'b11111 in one cycle:
   - Wake pulses appear in order 0,1,2,3,4.
   - Each sequence starts 1 cycle after the previous returns to IDLE.
   - seq_busy_o never drops for more than 1 cycle between sequences.
3. Cluster 2 on, busy=1, en dropped:
   - FSM holds in DN_DRAIN with clk_en_o[2]=1 and rst_n=1.
   - Busy falls at cycle k: rst_n[2]=0 at k+1, clk_en_o[2]=0 and cluster_on_o[2]=0 at k+1+8.
4. Toggle cluster_en_i[1] 1->0->1 during UP_RST:
   - Up-sequence completes.
   - Cluster 1 then sees a full down-then-up sequence, or no extra sequence, matching the en level when IDLE is re-entered.
5. rst_ni asserted during UP_RST of cluster 3: all outputs return to reset values within the same cycle; after release, the sequence restarts from IDLE.
6. With CHIMERA_PWR_SEQ_TIMEOUT_EN and TimeoutCycles=16, busy held high:
   - timeout_err_o[4] set after 16 drain cycles, then the forced shutdown.
   - A later power-up clears it.

Source files
------------

// File: rtl/chimera_cluster_pwr_seq_pkg.sv
// Shared constants and types for the Snitch cluster power sequencer.
// Optional drain timeout is enabled with CHIMERA_PWR_SEQ_TIMEOUT_EN.
package chimera_cluster_pwr_seq_pkg;

    localparam int unsigned ExtClusters            = 5;
    localparam int unsigned DefaultClkSettleCycles = 4;
    localparam int unsigned DefaultRstHoldCycles   = 8;
    localparam int unsigned DefaultCntWidth        = 16;
    localparam int unsigned DefaultTimeoutCycles   = 1024;

    typedef logic [ExtClusters-1:0] cluster_mask_t;

    typedef logic [2:0] pwr_seq_state_e;

    localparam pwr_seq_state_e IDLE     = 3'd0;
    localparam pwr_seq_state_e UP_CLK   = 3'd1;
    localparam pwr_seq_state_e UP_RST   = 3'd2;
    localparam pwr_seq_state_e UP_WAKE  = 3'd3;
    localparam pwr_seq_state_e DN_DRAIN = 3'd4;
    localparam pwr_seq_state_e DN_RST   = 3'd5;

endpackage

// File: rtl/chimera_cluster_pwr_seq_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module chimera_cluster_pwr_seq_rr_pick #(
    parameter int unsigned NumReq = 5,
    parameter int unsigned IdxW   = 3
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    localparam int unsigned SumW = IdxW + 1;

    logic [SumW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            // ptr + off never exceeds 2*NumReq-2, so one subtraction wraps it.
            cand = {1'b0, ptr_i} + SumW'(off);
            if (cand >= SumW'(NumReq)) begin
                cand = cand - SumW'(NumReq);
            end
            if (!valid_o && req_i[cand[IdxW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// Serialised clock-gate / reset / wake sequencer for the external Snitch clusters.
// Define CHIMERA_PWR_SEQ_TIMEOUT_EN to bound the drain wait on power-down.
module chimera_cluster_pwr_seq
    import chimera_cluster_pwr_seq_pkg::*;
#(
    parameter int unsigned  NumClusters     = ExtClusters,
    parameter int unsigned  ClkSettleCycles = DefaultClkSettleCycles,
    parameter int unsigned  RstHoldCycles   = DefaultRstHoldCycles,
    parameter int unsigned  CntWidth        = DefaultCntWidth,
    parameter int unsigned  TimeoutCycles   = DefaultTimeoutCycles,
    localparam int unsigned IdxW            = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] cluster_en_i,
    input  logic [NumClusters-1:0] cluster_busy_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic [NumClusters-1:0] wake_pulse_o,
    output logic [NumClusters-1:0] cluster_on_o,
    output logic                   seq_busy_o,
    output logic [IdxW-1:0]        active_idx_o,
    output logic [NumClusters-1:0] timeout_err_o
);

    localparam logic [CntWidth-1:0] ClkLoad   = CntWidth'(ClkSettleCycles - 1);
    localparam logic [CntWidth-1:0] RstLoad   = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] DrainLoad = CntWidth'(TimeoutCycles - 1);

    pwr_seq_state_e         state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [NumClusters-1:0] clk_en_q, clk_en_d;
    logic [NumClusters-1:0] rst_n_q, rst_n_d;
    logic [NumClusters-1:0] wake_q, wake_d;
    logic [NumClusters-1:0] on_q, on_d;
    logic [NumClusters-1:0] err_q, err_d;

    logic [NumClusters-1:0] pending;
    logic [IdxW-1:0]        gnt_idx;
    logic                   gnt_valid;
    logic                   cnt_zero;
    logic                   drain_done;

    assign pending  = cluster_en_i ^ on_q;
    assign cnt_zero = (cnt_q == '0);

    chimera_cluster_pwr_seq_rr_pick #(
        .NumReq (NumClusters),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .req_i   (pending),
        .ptr_i   (ptr_q),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        clk_en_d   = clk_en_q;
        rst_n_d    = rst_n_q;
        wake_d     = wake_q;
        on_d       = on_q;
        err_d      = err_q;
        drain_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    idx_d = gnt_idx;
                    ptr_d = (gnt_idx == IdxW'(NumClusters - 1)) ? '0 : gnt_idx + IdxW'(1);
                    if (cluster_en_i[gnt_idx]) begin
                        state_d           = UP_CLK;
                        clk_en_d[gnt_idx] = 1'b1;
                        cnt_d             = ClkLoad;
                    end else begin
                        state_d = DN_DRAIN;
                        cnt_d   = DrainLoad;
                    end
                end
            end
            UP_CLK: begin
                if (cnt_zero) begin
                    rst_n_d[idx_q] = 1'b1;
                    cnt_d          = RstLoad;
                    state_d        = UP_RST;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            UP_RST: begin
                if (cnt_zero) begin
                    wake_d[idx_q] = 1'b1;
                    state_d       = UP_WAKE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            UP_WAKE: begin
                wake_d[idx_q] = 1'b0;
                on_d[idx_q]   = 1'b1;
                err_d[idx_q]  = 1'b0;
                state_d       = IDLE;
            end
            DN_DRAIN: begin
                if (!cluster_busy_i[idx_q]) begin
                    drain_done = 1'b1;
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
                end else if (cnt_zero) begin
                    // Cluster never drained: flag it and shut it down anyway.
                    drain_done    = 1'b1;
                    err_d[idx_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
`endif
                end
                if (drain_done) begin
                    rst_n_d[idx_q] = 1'b0;
                    cnt_d          = RstLoad;
                    state_d        = DN_RST;
                end
            end
            DN_RST: begin
                if (cnt_zero) begin
                    clk_en_d[idx_q] = 1'b0;
                    on_d[idx_q]     = 1'b0;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            idx_q    <= '0;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            wake_q   <= '0;
            on_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            clk_en_q <= clk_en_d;
            rst_n_q  <= rst_n_d;
            wake_q   <= wake_d;
            on_q     <= on_d;
            err_q    <= err_d;
        end
    end

    assign clk_en_o       = clk_en_q;
    assign cluster_rst_no = rst_n_q;
    assign wake_pulse_o   = wake_q;
    assign cluster_on_o   = on_q;
    assign seq_busy_o     = (state_q != IDLE);
    assign active_idx_o   = idx_q;
`ifdef CHIMERA_PWR_SEQ_TIMEOUT_EN
    assign timeout_err_o  = err_q;
`else
    assign timeout_err_o  = '0;
`endif

endmodule
